// File: rtl/pmp_pkg.sv
// Shared definitions for the pattern-match controller: register map, FSM states
// and STATUS bit layout.
package pmp_pkg;

  localparam int unsigned MAX_PATLEN = 8;
  localparam int unsigned PidxW      = $clog2(MAX_PATLEN);

  localparam logic [4:0] OffCtrl    = 5'h00;
  localparam logic [4:0] OffPatlen  = 5'h04;
  localparam logic [4:0] OffPat     = 5'h08;
  localparam logic [4:0] OffText    = 5'h0C;
  localparam logic [4:0] OffStatus  = 5'h10;
  localparam logic [4:0] OffCount   = 5'h14;
  localparam logic [4:0] OffLastpos = 5'h18;
  localparam logic [4:0] OffEot     = 5'h1C;

  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlClear = 1;

  localparam int unsigned StatusBusy  = 0;
  localparam int unsigned StatusEmpty = 1;
  localparam int unsigned StatusFull  = 2;
  localparam int unsigned StatusOvf   = 3;
  localparam int unsigned StatusDone  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } pmp_state_e;

endpackage

// File: rtl/pmp_fifo.sv
// Byte-wide synchronous FIFO holding text awaiting the matcher; supports flush and
// a simultaneous push/pop when full.
module pmp_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [7:0]    mem_q [Depth];
  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i && (!full_o || pop_i) && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, do_pop};
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/pmp_ctrl.sv
// Memory-mapped streaming pattern matcher: counts (overlapping) occurrences of a
// 1..8 byte pattern in text pushed through a FIFO.
module pmp_ctrl
  import pmp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata
);

  localparam int unsigned WinBits = 8 * MAX_PATLEN;

  logic [31:0]  off;
  logic [4:0]   reg_sel;
  logic         in_win, wr_en;
  logic         wr_ctrl, wr_patlen, wr_pat, wr_text, wr_eot;
  logic         start, clear, patlen_ok;

  pmp_state_e                 state_q, state_d;
  logic [3:0]                 patlen_q, patlen_d;
  logic [MAX_PATLEN-1:0][7:0] pattern_q, pattern_d;
  logic [PidxW-1:0]           pidx_q, pidx_d;
  logic                       ovf_q, ovf_d;
  logic                       eot_q, eot_d;
  logic [15:0]                count_q, count_d;
  logic [15:0]                lastpos_q, lastpos_d;
  logic [15:0]                pos_q, pos_d;
  logic [WinBits-1:0]         window_q, window_d;

  logic [WinBits-1:0] cand;
  logic [7:0]         fifo_rdata;
  logic               fifo_full, fifo_empty, pop, overflow;
  logic               pat_hit, reach, match;
  logic [3:0]         pat_sel;
  logic [31:0]        status;
  logic               unused_bits;

  assign off       = daddr - BASE_ADDR;
  assign in_win    = (off < 32'd32);
  assign reg_sel   = {off[4:2], 2'b00};
  assign wr_en     = in_win && (dwe != 4'h0);
  assign wr_ctrl   = wr_en && (reg_sel == OffCtrl);
  assign wr_patlen = wr_en && (reg_sel == OffPatlen);
  assign wr_pat    = wr_en && (reg_sel == OffPat);
  assign wr_text   = wr_en && (reg_sel == OffText);
  assign wr_eot    = wr_en && (reg_sel == OffEot);
  assign start     = wr_ctrl && dwdata[CtrlStart];
  assign clear     = wr_ctrl && dwdata[CtrlClear];
  assign patlen_ok = (dwdata[7:0] >= 8'd1) && (dwdata[7:0] <= 8'(MAX_PATLEN));
  assign pop       = (state_q == StRun) && !fifo_empty && !clear;
  assign overflow  = wr_text && fifo_full && !pop;
  assign unused_bits = ^{dwdata[31:8], off[1:0]};

  pmp_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .flush_i(clear),
    .push_i (wr_text),
    .wdata_i(dwdata[7:0]),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Newest byte sits in cand[7:0]; pattern[0] lines up with the oldest of the
  // last patlen bytes.
  always_comb begin
    cand    = {window_q[WinBits-9:0], fifo_rdata};
    pat_hit = 1'b1;
    pat_sel = '0;
    for (int k = 0; k < MAX_PATLEN; k++) begin
      pat_sel = patlen_q - 4'(k + 1);
      if ((4'(k) < patlen_q) && (cand[8*k +: 8] != pattern_q[pat_sel[PidxW-1:0]])) begin
        pat_hit = 1'b0;
      end
    end
  end

  assign reach = ({1'b0, pos_q} + 17'd1) >= {13'b0, patlen_q};
  assign match = pop && reach && pat_hit;

  always_comb begin
    state_d   = state_q;
    patlen_d  = patlen_q;
    pattern_d = pattern_q;
    pidx_d    = pidx_q;
    ovf_d     = ovf_q;
    eot_d     = eot_q;
    count_d   = count_q;
    lastpos_d = lastpos_q;
    pos_d     = pos_q;
    window_d  = window_q;

    if (clear) begin
      state_d   = StIdle;
      pidx_d    = '0;
      ovf_d     = 1'b0;
      eot_d     = 1'b0;
      count_d   = '0;
      lastpos_d = '0;
      pos_d     = '0;
      window_d  = '0;
    end else begin
      if (start && (state_q != StRun)) begin
        state_d   = StRun;
        eot_d     = 1'b0;
        count_d   = '0;
        lastpos_d = '0;
        pos_d     = '0;
        window_d  = '0;
      end else if (state_q == StRun) begin
        if (pop) begin
          window_d = cand;
          pos_d    = pos_q + 16'd1;
          if (match) begin
            count_d   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            lastpos_d = pos_q;
          end
        end
        if (wr_eot) begin
          eot_d = 1'b1;
        end
        if (eot_q && fifo_empty) begin
          state_d = StDone;
        end
      end

      if (wr_patlen && patlen_ok && (state_q != StRun)) begin
        patlen_d = dwdata[3:0];
      end
      if (wr_pat && (state_q != StRun)) begin
        pattern_d[pidx_q] = dwdata[7:0];
        pidx_d            = pidx_q + PidxW'(1);
      end
      if (overflow) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      patlen_q  <= 4'd1;
      pattern_q <= '0;
      pidx_q    <= '0;
      ovf_q     <= 1'b0;
      eot_q     <= 1'b0;
      count_q   <= '0;
      lastpos_q <= '0;
      pos_q     <= '0;
      window_q  <= '0;
    end else begin
      state_q   <= state_d;
      patlen_q  <= patlen_d;
      pattern_q <= pattern_d;
      pidx_q    <= pidx_d;
      ovf_q     <= ovf_d;
      eot_q     <= eot_d;
      count_q   <= count_d;
      lastpos_q <= lastpos_d;
      pos_q     <= pos_d;
      window_q  <= window_d;
    end
  end

  always_comb begin
    status              = '0;
    status[StatusBusy]  = (state_q == StRun);
    status[StatusEmpty] = fifo_empty;
    status[StatusFull]  = fifo_full;
    status[StatusOvf]   = ovf_q;
    status[StatusDone]  = (state_q == StDone);
  end

  always_comb begin
    drdata = '0;
    if (in_win) begin
      case (reg_sel)
        OffPatlen:  drdata = {28'b0, patlen_q};
        OffStatus:  drdata = status;
        OffCount:   drdata = {16'b0, count_q};
        OffLastpos: drdata = {16'b0, lastpos_q};
        default:    drdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_ctrl.sv
// Bench for pmp_ctrl: directed scenarios plus randomized streams scored against a
// whole-stream substring-count model.
module tb_pmp_ctrl;

  localparam logic [31:0] Base    = 32'h0000_0400;
  localparam int          Depth   = 8;
  localparam logic [31:0] CTRL    = 32'h00;
  localparam logic [31:0] PATLEN  = 32'h04;
  localparam logic [31:0] PAT     = 32'h08;
  localparam logic [31:0] TEXT    = 32'h0C;
  localparam logic [31:0] STATUS  = 32'h10;
  localparam logic [31:0] COUNT   = 32'h14;
  localparam logic [31:0] LASTPOS = 32'h18;
  localparam logic [31:0] EOT     = 32'h1C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dwe;

  int errors = 0;
  int checks = 0;

  byte unsigned stream[$];
  byte unsigned pat_m[8];
  int           patlen_m;

  pmp_ctrl #(
    .BASE_ADDR (Base),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .daddr (daddr),
    .dwdata(dwdata),
    .dwe   (dwe),
    .drdata(drdata)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    daddr  = Base + off;
    dwdata = d;
    dwe    = 4'($urandom_range(1, 15));
    @(posedge clk);
    #1;
    dwe = 4'h0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d);
    daddr = addr;
    dwe   = 4'h0;
    #1;
    d = drdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    bit seen;
    seen = 1'b0;
    s    = '0;
    for (int i = 0; i < 200 && !seen; i++) begin
      rd(Base + STATUS, s);
      if (s[4]) seen = 1'b1;
      else idle(1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_wait: status=%h required done bit set", tag, s);
    end
  endtask

  // Count every (overlapping) occurrence of the pattern in the consumed stream.
  task automatic model_scan(output int cnt, output int last);
    bit ok;
    cnt  = 0;
    last = 0;
    for (int p = 0; p < stream.size(); p++) begin
      if (p + 1 >= patlen_m) begin
        ok = 1'b1;
        for (int i = 0; i < patlen_m; i++) begin
          if (stream[p - patlen_m + 1 + i] != pat_m[i]) ok = 1'b0;
        end
        if (ok) begin
          if (cnt < 65535) cnt++;
          last = p % 65536;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset  = 1'b1;
    daddr  = Base;
    dwdata = 32'h0;
    dwe    = 4'h0;
    idle(3);
    reset = 1'b0;
    rd(Base + STATUS, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL reset_status: got %h required %h", v, 32'h2); end
    rd(Base + PATLEN, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL reset_patlen: got %h required %h", v, 32'h1); end
    rd(Base + COUNT, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h required 0", v); end
    rd(Base + LASTPOS, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_lastpos: got %h required 0", v); end
    rd(Base + 32'h20, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL outside_window_high: got %h required 0", v); end
    rd(Base - 32'h4, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL outside_window_low: got %h required 0", v); end
    idle(1);
  endtask

  task automatic test_patlen_guard();
    logic [31:0] v;
    wr(PATLEN, 32'd9);
    wr(PATLEN, 32'd0);
    rd(Base + PATLEN, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL patlen_reject: got %0d required 1", v); end
    wr(PATLEN, 32'd5);
    wr(PATLEN, 32'd9);
    rd(Base + PATLEN, v);
    checks++; if (v !== 32'd5) begin errors++; $display("FAIL patlen_accept: got %0d required 5", v); end
    wr(CTRL, 32'h1);
    wr(PATLEN, 32'd3);
    rd(Base + PATLEN, v);
    checks++; if (v !== 32'd5) begin errors++; $display("FAIL patlen_in_run: got %0d required 5", v); end
    wr(CTRL, 32'h2);
  endtask

  task automatic test_example();
    logic [31:0] v;
    string txt;
    txt = "ababa";
    wr(CTRL, 32'h2);
    wr(PATLEN, 32'd3);
    wr(PAT, 32'h61);
    wr(PAT, 32'h62);
    wr(PAT, 32'h61);
    wr(CTRL, 32'h1);
    for (int i = 0; i < txt.len(); i++) wr(TEXT, {24'b0, txt[i]});
    wr(EOT, 32'h0);
    wait_done("example");
    rd(Base + COUNT, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL example_count: got %0d required 2", v); end
    rd(Base + LASTPOS, v);
    checks++; if (v !== 32'd4) begin errors++; $display("FAIL example_lastpos: got %0d required 4", v); end
    rd(Base + STATUS, v);
    checks++; if (v !== 32'h12) begin errors++; $display("FAIL example_status: got %h required %h", v, 32'h12); end
    idle(1);
  endtask

  task automatic test_latency();
    logic [31:0] v;
    wr(CTRL, 32'h2);
    wr(PATLEN, 32'd1);
    wr(PAT, 32'h78);
    wr(CTRL, 32'h1);
    wr(TEXT, 32'h78);
    rd(Base + COUNT, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL latency_before_pop: got %0d required 0", v); end
    idle(1);
    rd(Base + COUNT, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL latency_after_pop: got %0d required 1", v); end
    rd(Base + STATUS, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL latency_status_run: got %h required %h", v, 32'h3); end
    idle(1);
    wr(EOT, 32'h0);
    wait_done("latency");
    idle(1);
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    wr(CTRL, 32'h2);
    wr(PATLEN, 32'd1);
    wr(PAT, 32'h55);
    for (int i = 0; i < 9; i++) wr(TEXT, 32'h55);
    rd(Base + STATUS, v);
    checks++; if (v !== 32'h0C) begin errors++; $display("FAIL overflow_status: got %h required %h", v, 32'h0C); end
    wr(CTRL, 32'h1);
    wr(EOT, 32'h0);
    wait_done("overflow");
    rd(Base + COUNT, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL overflow_consumed: got %0d required 8", v); end
    rd(Base + LASTPOS, v);
    checks++; if (v !== 32'd7) begin errors++; $display("FAIL overflow_lastpos: got %0d required 7", v); end
    rd(Base + STATUS, v);
    checks++; if (v !== 32'h1A) begin errors++; $display("FAIL overflow_done_status: got %h required %h", v, 32'h1A); end
    idle(1);
  endtask

  task automatic test_pat_in_run();
    logic [31:0] v;
    string txt;
    txt = "qrqz";
    wr(CTRL, 32'h2);
    wr(PATLEN, 32'd2);
    wr(PAT, 32'h71);
    wr(CTRL, 32'h1);
    wr(PAT, 32'h7A);
    wr(EOT, 32'h0);
    wait_done("pat_run_a");
    wr(PAT, 32'h72);
    wr(CTRL, 32'h1);
    for (int i = 0; i < txt.len(); i++) wr(TEXT, {24'b0, txt[i]});
    wr(EOT, 32'h0);
    wait_done("pat_run_b");
    rd(Base + COUNT, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL pat_in_run_count: got %0d required 1", v); end
    rd(Base + LASTPOS, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL pat_in_run_lastpos: got %0d required 1", v); end
    idle(1);
  endtask

  task automatic test_clear_mid_run();
    logic [31:0] v;
    wr(CTRL, 32'h2);
    wr(PATLEN, 32'd2);
    for (int i = 0; i < 3; i++) wr(TEXT, 32'h41);
    wr(CTRL, 32'h1);
    rd(Base + STATUS, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL clear_pre_status: got %h required %h", v, 32'h1); end
    wr(CTRL, 32'h3);
    rd(Base + STATUS, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL clear_status: got %h required %h", v, 32'h2); end
    rd(Base + COUNT, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL clear_count: got %0d required 0", v); end
    rd(Base + PATLEN, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL clear_patlen_kept: got %0d required 2", v); end
    idle(1);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] v;
    wr(CTRL, 32'h2);
    wr(PATLEN, 32'd1);
    wr(PAT, 32'h71);
    for (int i = 0; i < 4; i++) wr(TEXT, 32'h71);
    wr(CTRL, 32'h1);
    reset  = 1'b1;
    daddr  = Base + TEXT;
    dwdata = 32'h71;
    dwe    = 4'hF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dwe   = 4'h0;
    rd(Base + STATUS, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL rst_run_status: got %h required %h", v, 32'h2); end
    rd(Base + PATLEN, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL rst_run_patlen: got %0d required 1", v); end
    rd(Base + COUNT, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_run_count: got %0d required 0", v); end
    idle(1);
    // Pattern byte must be back to 0 after reset.
    wr(CTRL, 32'h1);
    wr(TEXT, 32'h00);
    wr(EOT, 32'h0);
    wait_done("rst_run");
    rd(Base + COUNT, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL rst_pattern_zero: got %0d required 1", v); end
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] v;
    int cnt, last, k, m;
    byte unsigned b;
    for (int it = 0; it < 20; it++) begin
      wr(CTRL, 32'h2);
      stream.delete();
      patlen_m = $urandom_range(1, 8);
      wr(PATLEN, 32'(patlen_m));
      for (int i = 0; i < patlen_m; i++) begin
        pat_m[i] = 8'($urandom_range(97, 98));
        wr(PAT, {24'b0, pat_m[i]});
      end
      k = $urandom_range(0, 8);
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom_range(97, 98));
        stream.push_back(b);
        wr(TEXT, {24'b0, b});
      end
      wr(CTRL, 32'h1);
      m = $urandom_range(4, 24);
      for (int i = 0; i < m; i++) begin
        b = 8'($urandom_range(97, 98));
        stream.push_back(b);
        wr(TEXT, {24'b0, b});
      end
      wr(EOT, 32'h0);
      wait_done("random");
      model_scan(cnt, last);
      rd(Base + COUNT, v);
      checks++; if (v !== 32'(cnt)) begin errors++; $display("FAIL random_count it=%0d: got %0d required %0d", it, v, cnt); end
      rd(Base + LASTPOS, v);
      checks++; if (v !== 32'(last)) begin errors++; $display("FAIL random_lastpos it=%0d: got %0d required %0d", it, v, last); end
      rd(Base + STATUS, v);
      checks++; if (v !== 32'h12) begin errors++; $display("FAIL random_status it=%0d: got %h required %h", it, v, 32'h12); end
      idle(1);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] v;
    int n;
    n = 70000;
    wr(CTRL, 32'h2);
    wr(PATLEN, 32'd1);
    wr(PAT, 32'h78);
    wr(CTRL, 32'h1);
    daddr  = Base + TEXT;
    dwdata = 32'h78;
    dwe    = 4'hF;
    repeat (n) @(posedge clk);
    #1;
    dwe = 4'h0;
    wr(EOT, 32'h0);
    wait_done("saturate");
    rd(Base + COUNT, v);
    checks++; if (v !== 32'hFFFF) begin errors++; $display("FAIL saturate_count: got %h required %h", v, 32'hFFFF); end
    rd(Base + LASTPOS, v);
    checks++; if (v !== 32'((n - 1) % 65536)) begin errors++; $display("FAIL saturate_pos_wrap: got %0d required %0d", v, (n - 1) % 65536); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_patlen_guard();
    test_example();
    test_latency();
    test_overflow();
    test_pat_in_run();
    test_clear_mid_run();
    test_reset_mid_run();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmp_ctrl.md
PMP_CTRL -- requirements
Module: pmp_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0400, word-aligned base of the 32-byte register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, text FIFO depth, power of two.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port daddr  input  32  CPU data address.
REQ-006 SHALL have port dwdata  input  32  CPU write data; only [7:0] used except CTRL.
REQ-007 SHALL have port dwe  input  4  byte write enables; any nonzero bit with daddr in window = register write.
REQ-008 SHALL have port drdata  output  32  combinational read data for daddr; 0 outside window.

Function
REQ-009 Register map (offsets): 0x00 CTRL W (bit0 START, bit1 CLEAR); 0x04 PATLEN R/W; 0x08 PAT W; 0x0C TEXT W; 0x10 STATUS R; 0x14 COUNT R; 0x18 LASTPOS R; 0x1C EOT W.
REQ-010 PATLEN write accepted only for values 1..8 and only in IDLE/DONE; other values or writes ignored.
REQ-011 PAT write stores dwdata[7:0] at pattern[pidx], pidx increments mod 8; CLEAR resets pidx to 0; ignored in RUN.
REQ-012 TEXT write pushes dwdata[7:0] into FIFO in any state; push when full and no pop in that cycle is dropped and sets sticky OVF.
REQ-013 FSM states IDLE, RUN, DONE; IDLE --START--> RUN; RUN --(EOT flag && FIFO empty)--> DONE; DONE --START--> RUN; any state --CLEAR--> IDLE.
REQ-014 Entering RUN SHALL clear window, pos, COUNT, LASTPOS, EOT flag, DONE; FIFO contents preserved.
REQ-015 In RUN, each cycle FIFO non-empty: pop one byte, window <= {window[6:0], byte}, pos <= pos+1.
REQ-016 Match on pop when pos+1 >= PATLEN and last PATLEN bytes of {window, byte} equal pattern[0..PATLEN-1] (pattern[0] oldest); COUNT <= COUNT+1 (16-bit, saturating at 16'hFFFF), LASTPOS <= pos.
REQ-017 Match result visible on COUNT read the cycle after the pop edge; overlapping matches all counted.
REQ-018 EOT write sets EOT flag; honoured only in RUN; DONE entered the edge after the last pop with flag set.
REQ-019 STATUS = {27'b0, done, ovf, fifo_full, fifo_empty, busy}; busy = (state==RUN).
REQ-020 Simultaneous push and pop on full FIFO: both occur, no OVF. Simultaneous START and CLEAR: CLEAR wins.
REQ-021 CLEAR flushes FIFO, clears OVF, COUNT, LASTPOS, pos, window, EOT flag; PATLEN and pattern retained.
REQ-022 pos is 16-bit, wraps 16'hFFFF -> 0.

Reset
REQ-023 On reset: state IDLE, PATLEN=1, pattern all 0, pidx=0, FIFO empty, OVF=0, COUNT=0, LASTPOS=0, pos=0, window=0, EOT flag=0; drdata reflects these values (STATUS=32'h2).
REQ-024 Reset asserted mid-RUN SHALL abort in one edge; no register write accepted while reset high.

Structure
REQ-025 Package pmp_pkg SHALL hold register offsets, FSM state enum, MAX_PATLEN=8, STATUS bit indices.
REQ-026 Text buffer SHALL be sub-module pmp_fifo (synchronous, 8-bit wide, FIFO_DEPTH deep, full/empty flags, flush input).

Verification
REQ-027 PATLEN=3, PAT "aba", START, TEXT "ababa", EOT -> COUNT=2, LASTPOS=4, STATUS done=1, busy=0.
REQ-028 9 TEXT writes in IDLE with depth 8 -> STATUS ovf=1, full=1; START+EOT -> 8 bytes consumed, pos=8.
REQ-029 PATLEN write 9 then 0 -> PATLEN reads 1 (unchanged); PAT write during RUN -> pattern unchanged.
REQ-030 PATLEN=1, PAT "x", stream 70000 "x" bytes -> COUNT saturates 16'hFFFF.
REQ-031 CLEAR mid-RUN with FIFO holding 3 bytes -> next cycle STATUS=32'h2, COUNT=0, PATLEN retained.
REQ-032 reset asserted for one cycle during RUN -> all registers at REQ-023 values next cycle.
